fibonacci_seq_engine: RTL and testbench

Parametrised successor to the fixed 16-bit Fibonacci calculator. Computes the n-th term of a two-seed additive sequence, either Fibonacci (F0=0, F1=1) or Lucas (L0=2, L1=1), using one adder iterated over a small FSM. Adds a rising-edge start, an explicit busy flag, held results and optional overflow saturation. Sits beside the existing calculator as the general-purpose sequence unit for later labs.

---
 rtl/fibo_pkg.sv | 39 +++
 rtl/fibonacci_seq_engine.sv | 113 +++++++++++
 tb/tb_fibonacci_seq_engine.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fibo_pkg.sv
// Shared types and helpers for the sequence engine.
// Holds the state/mode enums, seed constants and the saturating adder.
package fibo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        FIBO  = 1'b0,
        LUCAS = 1'b1
    } mode_t;

    localparam int FIBO_SEED0  = 0;
    localparam int LUCAS_SEED0 = 2;
    localparam int MAX_W       = 64;

    // Width w comes in as an argument; operands must already fit in w bits.
    // Returns {carry, sum}, with sum forced to all-ones when carry is set.
    function automatic logic [MAX_W:0] sat_add(
        input logic [MAX_W-1:0] x,
        input logic [MAX_W-1:0] y,
        input int unsigned      w
    );
        logic [MAX_W:0]   s;
        logic [MAX_W-1:0] mask;
        logic             c;
        mask = {MAX_W{1'b1}} >> (MAX_W - w);
        s    = {1'b0, x} + {1'b0, y};
        c    = |(s >> w);
        if (c)
            sat_add = {1'b1, mask};
        else
            sat_add = {1'b0, s[MAX_W-1:0] & mask};
    endfunction

endpackage

// File: rtl/fibonacci_seq_engine.sv
// Iterative Fibonacci/Lucas term engine with rising-edge start.
// FIBO_SAT_OVERFLOW_EN selects saturating arithmetic with an overflow flag.
module fibonacci_seq_engine
    import fibo_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [IDX_W-1:0]  input_s,
    input  logic              mode,
    input  logic              begin_fibo,
    output logic [DATA_W-1:0] fibo_out,
    output logic              done,
    output logic              busy,
    output logic              overflow
);

    state_t             state;
    logic               begin_q;
    logic               start;
    logic [IDX_W-1:0]   count;
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [DATA_W-1:0]  next_b;
    logic [DATA_W-1:0]  seed0;

    assign start = begin_fibo & ~begin_q;
    assign busy  = (state == CALC);
    assign seed0 = (mode_t'(mode) == LUCAS) ? DATA_W'(LUCAS_SEED0)
                                            : DATA_W'(FIBO_SEED0);

`ifdef FIBO_SAT_OVERFLOW_EN
    logic               a_sat;
    logic               b_sat;
    logic               ovf_q;
    logic               carry;
    logic [MAX_W:0]     sum_w;
    logic               sum_unused;

    always_comb begin
        sum_w      = sat_add(MAX_W'(a), MAX_W'(b), DATA_W);
        next_b     = sum_w[DATA_W-1:0];
        carry      = sum_w[MAX_W];
        sum_unused = ^sum_w[MAX_W-1:DATA_W];
    end

    assign overflow = ovf_q;
`else
    always_comb begin
        next_b = a + b;
    end

    assign overflow = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            begin_q  <= 1'b0;
            count    <= '0;
            a        <= '0;
            b        <= '0;
            fibo_out <= '0;
            done     <= 1'b0;
`ifdef FIBO_SAT_OVERFLOW_EN
            a_sat    <= 1'b0;
            b_sat    <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            begin_q <= begin_fibo;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        count <= input_s;
                        a     <= seed0;
                        b     <= DATA_W'(1);
                        done  <= 1'b0;
                        state <= CALC;
`ifdef FIBO_SAT_OVERFLOW_EN
                        a_sat <= 1'b0;
                        b_sat <= 1'b0;
                        ovf_q <= 1'b0;
`endif
                    end
                end
                CALC: begin
                    if (count != '0) begin
                        a     <= b;
                        b     <= next_b;
                        count <= count - 1'b1;
`ifdef FIBO_SAT_OVERFLOW_EN
                        // b's flag is sticky; a only inherits it on the shift
                        a_sat <= b_sat;
                        b_sat <= b_sat | a_sat | carry;
`endif
                    end else begin
                        fibo_out <= a;
                        done     <= 1'b1;
                        state    <= DONE;
`ifdef FIBO_SAT_OVERFLOW_EN
                        ovf_q    <= a_sat;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fibonacci_seq_engine.sv
// Self-checking bench for fibonacci_seq_engine.
// Reference terms come from exact 64-bit arithmetic, then wrap/saturate.
module tb_fibonacci_seq_engine;

    localparam int DATA_W = 16;
    localparam int IDX_W  = 5;

    logic              clk;
    logic              reset_n;
    logic [IDX_W-1:0]  input_s;
    logic              mode;
    logic              begin_fibo;
    logic [DATA_W-1:0] fibo_out;
    logic              done;
    logic              busy;
    logic              overflow;

    int checks;
    int errors;

    fibonacci_seq_engine #(
        .DATA_W(DATA_W),
        .IDX_W (IDX_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .input_s   (input_s),
        .mode      (mode),
        .begin_fibo(begin_fibo),
        .fibo_out  (fibo_out),
        .done      (done),
        .busy      (busy),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint ref_term(input int n, input bit lucas);
        longint t0, t1, t;
        t0 = lucas ? 64'd2 : 64'd0;
        t1 = 64'd1;
        for (int i = 0; i < n; i++) begin
            t  = t0 + t1;
            t0 = t1;
            t1 = t;
        end
        return t0;
    endfunction

    task automatic expect_of(input int n, input bit lucas,
                             output logic [DATA_W-1:0] v, output logic ov);
        longint t;
        t = ref_term(n, lucas);
`ifdef FIBO_SAT_OVERFLOW_EN
        if (t >= (64'd1 << DATA_W)) begin
            v  = '1;
            ov = 1'b1;
        end else begin
            v  = t[DATA_W-1:0];
            ov = 1'b0;
        end
`else
        v  = t[DATA_W-1:0];
        ov = 1'b0;
`endif
    endtask

    // Drives one start, returns the result; lat counts negedges after setup
    task automatic run_calc(input int n, input bit md, input int hold,
                            output logic [DATA_W-1:0] res, output logic ovf,
                            output int lat, output logic done_first,
                            output logic busy_first, output bit tmo);
        @(negedge clk);
        begin_fibo = 1'b0;
        @(negedge clk);
        input_s    = IDX_W'(n);
        mode       = md;
        begin_fibo = 1'b1;
        lat        = 0;
        tmo        = 1'b1;
        done_first = 1'bx;
        busy_first = 1'bx;
        repeat (n + 40) begin
            @(negedge clk);
            lat++;
            if (lat >= hold) begin_fibo = 1'b0;
            if (lat == 1) begin
                done_first = done;
                busy_first = busy;
            end
            if (done) begin
                tmo = 1'b0;
                break;
            end
        end
        begin_fibo = 1'b0;
        res = fibo_out;
        ovf = overflow;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        input_s    = '0;
        mode       = 1'b0;
        begin_fibo = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({fibo_out, done, busy, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_values got out=%0d done=%b busy=%b ovf=%b want all 0",
                     fibo_out, done, busy, overflow);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_one(input string nm, input int n, input bit md,
                            input int hold);
        logic [DATA_W-1:0] res, ev;
        logic ovf, eov, df, bf;
        int lat;
        bit tmo;
        expect_of(n, md, ev, eov);
        run_calc(n, md, hold, res, ovf, lat, df, bf, tmo);
        checks++;
        if (tmo) begin
            errors++;
            $display("FAIL %s_timeout n=%0d no done within budget", nm, n);
        end
        checks++;
        if (res !== ev || ovf !== eov) begin
            errors++;
            $display("FAIL %s_result n=%0d mode=%0d got %0d ovf=%b want %0d ovf=%b",
                     nm, n, md, res, ovf, ev, eov);
        end
        checks++;
        if (lat !== n + 2 || busy !== 1'b0 || bf !== 1'b1) begin
            errors++;
            $display("FAIL %s_timing n=%0d got lat=%0d busy=%b busy1=%b want lat=%0d busy=0 busy1=1",
                     nm, n, lat, busy, bf, n + 2);
        end
    endtask

    task automatic test_fibo_basic();
        test_one("fibo5", 5, 1'b0, 2);
        test_one("fibo9", 9, 1'b0, 2);
        test_one("fibo12", 12, 1'b0, 2);
        test_one("fibo0", 0, 1'b0, 1);
    endtask

    task automatic test_lucas();
        test_one("lucas0", 0, 1'b1, 1);
        test_one("lucas5", 5, 1'b1, 1);
        test_one("lucas9", 9, 1'b1, 1);
        test_one("lucas12", 12, 1'b1, 1);
    endtask

    task automatic test_overflow_boundary();
        logic [DATA_W-1:0] res;
        logic ovf, df, bf;
        int lat;
        bit tmo;
        run_calc(24, 1'b0, 1, res, ovf, lat, df, bf, tmo);
        checks++;
        if (tmo || res !== 16'd46368 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_n24 got %0d ovf=%b tmo=%0d want 46368 ovf=0",
                     res, ovf, tmo);
        end
        run_calc(25, 1'b0, 1, res, ovf, lat, df, bf, tmo);
        checks++;
`ifdef FIBO_SAT_OVERFLOW_EN
        if (tmo || res !== 16'd65535 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_n25 got %0d ovf=%b tmo=%0d want 65535 ovf=1",
                     res, ovf, tmo);
        end
`else
        if (tmo || res !== 16'd9489 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_n25 got %0d ovf=%b tmo=%0d want 9489 ovf=0",
                     res, ovf, tmo);
        end
`endif
        test_one("lucas23", 23, 1'b1, 1);
        test_one("lucas24", 24, 1'b1, 1);
        test_one("fibo31", 31, 1'b0, 1);
    endtask

    task automatic test_held_start();
        int rises, highs;
        logic pb;
        @(negedge clk);
        begin_fibo = 1'b0;
        @(negedge clk);
        input_s    = IDX_W'(3);
        mode       = 1'b0;
        begin_fibo = 1'b1;
        rises = 0;
        highs = 0;
        pb    = busy;
        for (int i = 1; i <= 36; i++) begin
            @(negedge clk);
            if (busy && !pb) rises++;
            if (busy) highs++;
            pb = busy;
            if (i == 30) begin_fibo = 1'b0;
        end
        checks++;
        if (rises !== 1 || highs !== 4) begin
            errors++;
            $display("FAIL held_busy got rises=%0d highs=%0d want 1 and 4",
                     rises, highs);
        end
        checks++;
        if (done !== 1'b1 || fibo_out !== 16'd2) begin
            errors++;
            $display("FAIL held_result got done=%b out=%0d want done=1 out=2",
                     done, fibo_out);
        end
    endtask

    task automatic test_mid_calc_restart();
        logic [DATA_W-1:0] ev, res;
        logic eov, ovf, df, bf;
        int lat;
        bit tmo;
        expect_of(20, 1'b0, ev, eov);
        @(negedge clk);
        begin_fibo = 1'b0;
        @(negedge clk);
        input_s    = IDX_W'(20);
        mode       = 1'b0;
        begin_fibo = 1'b1;
        lat = 0;
        tmo = 1'b1;
        repeat (70) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin_fibo = 1'b0;
            if (lat == 4) begin
                input_s    = IDX_W'(5);
                mode       = 1'b1;
                begin_fibo = 1'b1;
            end
            if (lat == 5) begin_fibo = 1'b0;
            if (done) begin
                tmo = 1'b0;
                break;
            end
        end
        checks++;
        if (tmo || fibo_out !== ev || lat !== 22) begin
            errors++;
            $display("FAIL midcalc_ignore got %0d lat=%0d tmo=%0d want %0d lat=22",
                     fibo_out, lat, tmo, ev);
        end
        repeat (3) @(negedge clk);
        run_calc(7, 1'b0, 1, res, ovf, lat, df, bf, tmo);
        checks++;
        if (df !== 1'b0 || bf !== 1'b1) begin
            errors++;
            $display("FAIL done_restart_drop got done=%b busy=%b want done=0 busy=1",
                     df, bf);
        end
        checks++;
        if (tmo || res !== 16'd13) begin
            errors++;
            $display("FAIL done_restart_result got %0d want 13", res);
        end
    endtask

    task automatic test_async_reset();
        logic [DATA_W-1:0] res;
        logic ovf, df, bf;
        int lat;
        bit tmo;
        @(negedge clk);
        begin_fibo = 1'b0;
        @(negedge clk);
        input_s    = IDX_W'(20);
        mode       = 1'b0;
        begin_fibo = 1'b1;
        @(negedge clk);
        begin_fibo = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || fibo_out === '0) begin
            errors++;
            $display("FAIL areset_pre got busy=%b out=%0d want busy=1 out!=0",
                     busy, fibo_out);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({fibo_out, done, busy, overflow} !== '0) begin
            errors++;
            $display("FAIL areset_async got out=%0d done=%b busy=%b ovf=%b want all 0",
                     fibo_out, done, busy, overflow);
        end
        @(negedge clk);
        reset_n = 1'b1;
        run_calc(10, 1'b0, 1, res, ovf, lat, df, bf, tmo);
        checks++;
        if (tmo || res !== 16'd55 || lat !== 12) begin
            errors++;
            $display("FAIL areset_after got %0d lat=%0d want 55 lat=12", res, lat);
        end
    endtask

    task automatic test_random();
        int n, h;
        bit md;
        for (int k = 0; k < 12; k++) begin
            n  = $urandom_range(0, 31);
            md = 1'($urandom_range(0, 1));
            h  = $urandom_range(1, 4);
            test_one("rand", n, md, h);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fibo_basic();
        test_lucas();
        test_overflow_boundary();
        test_held_start();
        test_mid_calc_restart();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
